// File: rtl/beam_pkg.sv
// Shared definitions for the beam-forming scan controller: FSM states, default
// geometry and the shift-to-LED direction map used by the LED driver too.
package beam_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_WINDOW     = 30;
  localparam int DEF_NUM_SHIFTS = 60;
  localparam int DEF_ACC_WIDTH  = 22;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SCAN,
    UPDATE,
    DONE
  } state_t;

  // Bands are narrower at the extremes where the angular resolution is coarse.
  function automatic logic [7:0] shift_to_led(input logic [5:0] shift);
    logic [7:0] led;
    if (shift <= 6'd2)       led = 8'h01;
    else if (shift <= 6'd9)  led = 8'h02;
    else if (shift <= 6'd19) led = 8'h04;
    else if (shift <= 6'd29) led = 8'h08;
    else if (shift <= 6'd39) led = 8'h10;
    else if (shift <= 6'd49) led = 8'h20;
    else if (shift <= 6'd56) led = 8'h40;
    else                     led = 8'h80;
    return led;
  endfunction

endpackage

// File: rtl/sad_accum.sv
// Serial sum-of-absolute-differences accumulator: one |a-b| term per enabled
// cycle, cleared synchronously by clear.
module sad_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH:0] mag;
  logic [ACC_WIDTH-1:0] acc_reg;

  // Sign-extend by one bit so the difference of any two samples cannot wrap.
  always_comb begin
    diff = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    mag  = diff[DATA_WIDTH] ? (~diff + 1'b1) : diff;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else if (enable) begin
      acc_reg <= acc_reg + {{(ACC_WIDTH-DATA_WIDTH-1){1'b0}}, mag};
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/beam_scan_ctrl.sv
// Frame capture, shift scan and minimum-SAD tracking for the two-microphone
// correlator; publishes the winning shift as an LED direction pattern.
module beam_scan_ctrl
  import beam_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int NUM_SHIFTS = DEF_NUM_SHIFTS,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic [DATA_WIDTH-1:0] right_in,
  output logic                  busy,
  output logic                  overrun,
  output logic                  result_valid,
  output logic [5:0]            best_shift,
  output logic [ACC_WIDTH-1:0]  best_sad,
  output logic [7:0]            led_pattern
);

  localparam int FRAME = 3 * WINDOW;
  localparam int CNT_W = $clog2(FRAME);
  localparam int J_W   = $clog2(WINDOW);

  state_t state_reg, state_next;

  logic [CNT_W-1:0]     cnt_reg;
  logic [J_W-1:0]       j_reg;
  logic [5:0]           s_reg;
  logic [5:0]           win_reg;
  logic [ACC_WIDTH-1:0] min_reg;
  logic [ACC_WIDTH-1:0] acc;

  logic [DATA_WIDTH-1:0] left_mem  [FRAME];
  logic [DATA_WIDTH-1:0] right_mem [WINDOW];

  logic cnt_last, j_last, s_last, in_ref_window;
  logic [CNT_W-1:0] l_raddr;
  logic [J_W-1:0]   r_waddr;

  assign cnt_last      = (cnt_reg == CNT_W'(FRAME - 1));
  assign j_last        = (j_reg == J_W'(WINDOW - 1));
  assign s_last        = (s_reg == 6'(NUM_SHIFTS - 1));
  assign in_ref_window = (cnt_reg >= CNT_W'(WINDOW)) && (cnt_reg < CNT_W'(2 * WINDOW));
  assign l_raddr       = CNT_W'(j_reg) + CNT_W'(s_reg);
  assign r_waddr       = J_W'(cnt_reg - CNT_W'(WINDOW));

  // Only the middle third of the right channel is ever compared against.
  always_ff @(posedge clk) begin
    if (state_reg == CAPTURE && sample_valid) begin
      left_mem[cnt_reg] <= left_in;
      if (in_ref_window) begin
        right_mem[r_waddr] <= right_in;
      end
    end
  end

  sad_accum #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sad (
    .clk   (clk),
    .reset (reset),
    .clear (state_reg != SCAN),
    .enable(state_reg == SCAN),
    .a     (left_mem[l_raddr]),
    .b     (right_mem[j_reg]),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CAPTURE;
      CAPTURE: if (sample_valid && cnt_last) state_next = SCAN;
      SCAN:    if (j_last) state_next = UPDATE;
      UPDATE:  state_next = s_last ? DONE : SCAN;
      DONE:    state_next = continuous ? CAPTURE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg == CAPTURE) || (state_reg == SCAN) || (state_reg == UPDATE);
  assign overrun = sample_valid && ((state_reg == SCAN) || (state_reg == UPDATE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg      <= '0;
      j_reg        <= '0;
      s_reg        <= '0;
      win_reg      <= '0;
      min_reg      <= '0;
      result_valid <= 1'b0;
      best_shift   <= '0;
      best_sad     <= '0;
      led_pattern  <= 8'h00;
    end else begin
      result_valid <= 1'b0;
      case (state_reg)
        IDLE: cnt_reg <= '0;
        CAPTURE: begin
          if (sample_valid) begin
            cnt_reg <= cnt_last ? '0 : cnt_reg + 1'b1;
            if (cnt_last) begin
              s_reg   <= '0;
              j_reg   <= '0;
              win_reg <= '0;
              min_reg <= '1;
            end
          end
        end
        SCAN: j_reg <= j_last ? '0 : j_reg + 1'b1;
        UPDATE: begin
          // Strict compare: equal SADs keep the earlier shift.
          if (acc < min_reg) begin
            min_reg <= acc;
            win_reg <= s_reg;
          end
          if (!s_last) s_reg <= s_reg + 1'b1;
          j_reg <= '0;
        end
        DONE: begin
          best_shift   <= win_reg;
          best_sad     <= min_reg;
          led_pattern  <= shift_to_led(win_reg);
          result_valid <= 1'b1;
          cnt_reg      <= '0;
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// Randomized scoreboard bench for beam_scan_ctrl: a direct SAD search model
// predicts each frame's result, a monitor checks every result_valid pulse.
module tb_beam_scan_ctrl;

  localparam int W  = 30;
  localparam int F  = 90;
  localparam int NS = 60;
  localparam int LATENCY = 1862;

  logic        clk;
  logic        reset;
  logic        start;
  logic        continuous;
  logic        sample_valid;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        busy;
  logic        overrun;
  logic        result_valid;
  logic [5:0]  best_shift;
  logic [21:0] best_sad;
  logic [7:0]  led_pattern;

  beam_scan_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .continuous  (continuous),
    .sample_valid(sample_valid),
    .left_in     (left_in),
    .right_in    (right_in),
    .busy        (busy),
    .overrun     (overrun),
    .result_valid(result_valid),
    .best_shift  (best_shift),
    .best_sad    (best_sad),
    .led_pattern (led_pattern)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int shift;
    int sad;
    int led;
    int issue;
    bit busy_after;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;
  int results_seen = 0;
  int overrun_seen = 0;

  logic signed [15:0] fl [F];
  logic signed [15:0] fr [F];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int led_of(input int s);
    if (s < 3)  return 'h01;
    if (s < 10) return 'h02;
    if (s < 20) return 'h04;
    if (s < 30) return 'h08;
    if (s < 40) return 'h10;
    if (s < 50) return 'h20;
    if (s < 57) return 'h40;
    return 'h80;
  endfunction

  // Exhaustive search: compare left window at every shift with the middle
  // third of the right frame, keep the first minimum.
  task automatic push_expect(input bit busy_after);
    exp_t e;
    int best, bs;
    best = 32'h7fffffff;
    bs = 0;
    for (int s = 0; s < NS; s++) begin
      int sad = 0;
      for (int j = 0; j < W; j++) begin
        int d = int'(fl[j + s]) - int'(fr[W + j]);
        sad += (d < 0) ? -d : d;
      end
      if (sad < best) begin
        best = sad;
        bs = s;
      end
    end
    e.shift = bs;
    e.sad = best;
    e.led = led_of(bs);
    e.issue = cyc;
    e.busy_after = busy_after;
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        if (overrun) overrun_seen++;
        if (result_valid) begin
          results_seen++;
          if (sb_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = sb_q.pop_front();
            $display("result %0d: shift=%0d sad=%0d led=%02h latency=%0d (want shift=%0d sad=%0d)",
                     results_seen, best_shift, best_sad, led_pattern, cyc - e.issue, e.shift, e.sad);
            check("best_shift", best_shift, e.shift);
            check("best_sad", best_sad, e.sad);
            check("led_pattern", led_pattern, e.led);
            check("latency", cyc - e.issue, LATENCY);
            check("busy_after_done", busy, e.busy_after);
          end
        end
      end
    end
  end

  task automatic drive_frame(input int gap, input bit do_start, input bit poke, input bit busy_after);
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int n = 0; n < F; n++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        start = poke && ($urandom_range(0, 1) == 1);
        sample_valid = 1'b0;
        left_in = 16'($urandom);
        right_in = 16'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      sample_valid = 1'b1;
      left_in = fl[n];
      right_in = fr[n];
      if (n == F - 1) push_expect(busy_after);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_result(input int target);
    for (int i = 0; i < 4000 && results_seen < target; i++) @(negedge clk);
    check("result_arrived", results_seen >= target, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int n = 0; n < F; n++) begin
      fl[n] = 16'(int'($urandom_range(hi - lo, 0)) + lo);
      fr[n] = 16'(int'($urandom_range(hi - lo, 0)) + lo);
    end
  endtask

  initial begin
    int base;
    reset = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    sample_valid = 1'b0;
    left_in = '0;
    right_in = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_best_shift", best_shift, 0);
    check("rst_best_sad", best_sad, 0);
    check("rst_led", led_pattern, 0);
    @(negedge clk);
    reset = 1'b1;

    // Samples in IDLE are ignored without an overrun pulse.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      left_in = 16'($urandom);
      right_in = 16'($urandom);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    #1;
    check("idle_no_overrun", overrun_seen, 0);
    check("idle_not_busy", busy, 0);

    // Identical ramp channels.
    for (int n = 0; n < F; n++) begin
      fl[n] = 16'(n);
      fr[n] = 16'(n);
    end
    drive_frame(0, 1, 0, 0);
    wait_result(1);

    // Right channel is the left delayed by five samples.
    for (int n = 0; n < F; n++) fl[n] = 16'($urandom);
    for (int n = 0; n < F; n++) fr[n] = (n >= 5) ? fl[n - 5] : 16'($urandom);
    drive_frame(0, 1, 0, 0);
    wait_result(2);

    // All zero: every shift ties.
    for (int n = 0; n < F; n++) begin
      fl[n] = '0;
      fr[n] = '0;
    end
    drive_frame(0, 1, 0, 0);
    wait_result(3);

    // Extreme opposite values.
    for (int n = 0; n < F; n++) begin
      fl[n] = 16'h7FFF;
      fr[n] = 16'h8000;
    end
    drive_frame(0, 1, 0, 0);
    wait_result(4);

    // Sparse valid, start re-pulsed during capture, samples arriving in scan.
    fill_random(-40, 40);
    base = overrun_seen;
    drive_frame(2, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      repeat (20 + $urandom_range(0, 20)) @(negedge clk);
      sample_valid = 1'b1;
      start = 1'b1;
      left_in = 16'($urandom);
      right_in = 16'($urandom);
      @(negedge clk);
      sample_valid = 1'b0;
      start = 1'b0;
    end
    wait_result(5);
    check("overrun_pulses", overrun_seen - base, 4);

    // Continuous mode re-enters capture straight after DONE.
    fill_random(-1000, 1000);
    continuous = 1'b1;
    drive_frame(0, 1, 0, 1);
    wait_result(6);
    continuous = 1'b0;
    check("continuous_capture", busy, 1);
    fill_random(-32768, 32767);
    drive_frame(1, 0, 0, 0);
    wait_result(7);

    // A few more random frames with varied value ranges.
    for (int f = 0; f < 3; f++) begin
      fill_random(-20 * (f + 1), 20 * (f + 1));
      drive_frame(f, 1, 0, 0);
      wait_result(8 + f);
    end

    // Reset mid-scan aborts the frame and publishes nothing.
    fill_random(-100, 100);
    drive_frame(0, 1, 0, 0);
    void'(sb_q.pop_back());
    repeat (800) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_led", led_pattern, 0);
    check("abort_best_sad", best_sad, 0);
    check("abort_result_valid", result_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    base = results_seen;
    repeat (2200) @(negedge clk);
    #1;
    check("abort_no_result", results_seen - base, 0);
    check("abort_idle", busy, 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
